id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage LEGv8 core; sits directly downstream of the instruction decoder.
- Captures the decoder's control bits plus decode-stage operands each cycle and presents them to EX.
- Detects load-use hazards: stalls IF/ID and inserts a bubble.
- Squashes the captured instruction on a branch-taken flush.
- Keeps a saturating count of load-use bubbles.

Parameters:
WIDTH, 64, datapath width (operands, immediate, PC)
CNT_W, 16, bubble counter width
ZERO_REG, 31, register index hardwired to zero (XZR); never a hazard source

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_flagenable  in  1  decoder control
id_memtoreg  in  1  decoder control
id_memread  in  1  decoder control
id_memwrite  in  1  decoder control
id_alusrc  in  1  decoder control
id_regwrite  in  1  decoder control
id_aluop  in  3  decoder ALU op
id_rd  in  5  destination register index
id_rn  in  5  first source index
id_rb  in  5  second source index (already reg2loc-selected)
id_rb_used  in  1  second source is read (R-type, STUR, CBZ)
id_data1  in  WIDTH  register file read data 1
id_data2  in  WIDTH  register file read data 2
id_imm  in  WIDTH  sign/zero-extended immediate
id_pc  in  WIDTH  PC of decode instruction
flush  in  1  branch taken; squash instruction in decode
stall  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  EX slot holds a real instruction
ex_flagenable, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered controls
ex_aluop  out  3  registered ALU op
ex_rd, ex_rn, ex_rb  out  5 each  registered indices
ex_data1, ex_data2, ex_imm, ex_pc  out  WIDTH each  registered operands
bubble_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, any time, including mid-stall): every registered output = 0 and bubble_count = 0, immediately. stall is then 0 because ex_valid = 0.
- hazard (combinational) = ex_valid & ex_memread & (ex_rd != ZERO_REG) & id_valid & ((ex_rd == id_rn) | (id_rb_used & (ex_rd == id_rb))).
- stall = hazard & ~flush.
- Per rising edge, in priority order:
  1. flush = 1: load bubble; bubble_count unchanged.
  2. hazard = 1: load bubble; bubble_count += 1, saturating at 2^CNT_W-1.
  3. Otherwise: load every id_* field into its ex_* counterpart; ex_valid = id_valid.
- Bubble: all ex_* outputs = 0, including ex_valid and the data fields. A bubble therefore never writes registers, memory or flags.
- id_valid = 0 with no flush and no hazard: fields are still captured and ex_valid = 0. Downstream must gate every side effect on ex_valid; the block additionally forces ex_regwrite, ex_memwrite and ex_flagenable to 0 whenever the captured id_valid = 0.
- Latency: 1 cycle, ID to EX.
- Load-use penalty: exactly 1 cycle. Next cycle ex_memread = 0, so hazard clears and the held instruction is captured.
- A consumer at index ZERO_REG never stalls.
- The same load followed by two consumers stalls only the first one; the second is covered by forwarding.
- flush and hazard in the same cycle: flush wins, stall = 0, counter not incremented.
- A non-load producer (e.g. ADDI) never stalls.

Test Plan:
- Reset 0→1 mid-cycle while ex_valid=1, ex_rd=5 → all outputs 0 asynchronously, before the next edge; bubble_count=0.
- Normal capture: id ADDI (regwrite=1, alusrc=1, aluop=010, rd=3, rn=2, imm=7, pc=0x40) → next edge ex_* match exactly, ex_valid=1, stall=0 throughout.
- Load-use: LDUR rd=4 in EX, id ADD rn=4 rb=6 rb_used=1.
  - Edge 1: stall=1 for that cycle, then EX = bubble, bubble_count=1.
  - Edge 2: ADD is captured with rn=4, stall=0.
- No hazard cases (stall=0, bubble_count unchanged):
  - LDUR rd=31 then id rn=31;
  - LDUR rd=4 then id rb=4 with rb_used=0;
  - ADDS rd=4 then id rn=4.
- Flush + hazard in the same cycle (LDUR rd=4 in EX, id rn=4, flush=1) → stall=0, next EX = bubble, bubble_count unchanged; id_valid=0 with regwrite=1 → captured ex_regwrite=0.
- Saturation with CNT_W=2: drive 5 consecutive load-use hazards → bubble_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage LEGv8 core. It captures the decoder's controls and operands for EX.
// Latency: 1 cycle from ID to EX. A load-use bubble costs exactly 1 cycle.
// Backpressure: 'stall' is combinational and holds PC and IF/ID while a bubble is inserted. 'flush' squashes the decode slot.
// Ports: clk/reset (async, active-high); id_* decode-stage controls, register indices and operands; flush (branch taken);
//        stall (hold upstream stages); ex_* registered controls, indices and operands; bubble_count (saturating load-use bubble count).
module id_ex_reg #(
  parameter int WIDTH    = 64,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_flagenable,
  input  logic             id_memtoreg,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic [2:0]       id_aluop,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rb,
  input  logic             id_rb_used,
  input  logic [WIDTH-1:0] id_data1,
  input  logic [WIDTH-1:0] id_data2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [WIDTH-1:0] id_pc,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_flagenable,
  output logic             ex_memtoreg,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic [2:0]       ex_aluop,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_rn,
  output logic [4:0]       ex_rb,
  output logic [WIDTH-1:0] ex_data1,
  output logic [WIDTH-1:0] ex_data2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [WIDTH-1:0] ex_pc,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [4:0]       ZR      = 5'(ZERO_REG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             valid;
    logic             flagenable;
    logic             memtoreg;
    logic             memread;
    logic             memwrite;
    logic             alusrc;
    logic             regwrite;
    logic [2:0]       aluop;
    logic [4:0]       rd;
    logic [4:0]       rn;
    logic [4:0]       rb;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
  } ex_t;

  ex_t              ex_q;
  ex_t              ex_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hazard;

  // A load in EX whose destination is read by the real instruction in decode.
  // XZR never carries a value, so it cannot be a hazard source.
  always_comb begin
    hazard = ex_q.valid & ex_q.memread & (ex_q.rd != ZR) & id_valid &
             ((ex_q.rd == id_rn) | (id_rb_used & (ex_q.rd == id_rb)));
  end

  // A flush discards the decode instruction, so there is nothing to hold.
  assign stall = hazard & ~flush;

  always_comb begin
    ex_d  = '0;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (hazard) begin
      ex_d = '0;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d.valid      = id_valid;
      // Side-effecting controls are also killed locally for an empty slot.
      ex_d.flagenable = id_flagenable & id_valid;
      ex_d.memtoreg   = id_memtoreg;
      ex_d.memread    = id_memread;
      ex_d.memwrite   = id_memwrite & id_valid;
      ex_d.alusrc     = id_alusrc;
      ex_d.regwrite   = id_regwrite & id_valid;
      ex_d.aluop      = id_aluop;
      ex_d.rd         = id_rd;
      ex_d.rn         = id_rn;
      ex_d.rb         = id_rb;
      ex_d.data1      = id_data1;
      ex_d.data2      = id_data2;
      ex_d.imm        = id_imm;
      ex_d.pc         = id_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_flagenable = ex_q.flagenable;
  assign ex_memtoreg   = ex_q.memtoreg;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_alusrc     = ex_q.alusrc;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_aluop      = ex_q.aluop;
  assign ex_rd         = ex_q.rd;
  assign ex_rn         = ex_q.rn;
  assign ex_rb         = ex_q.rb;
  assign ex_data1      = ex_q.data1;
  assign ex_data2      = ex_q.data2;
  assign ex_imm        = ex_q.imm;
  assign ex_pc         = ex_q.pc;
  assign bubble_count  = cnt_q;

endmodule
